// File: rtl/block_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : block_align_ctrl
// Purpose  : Receive-side 128b/130b block-alignment controller. Checks the
//            2-bit sync header of each deserialized word, requests one-bit
//            boundary slips until LOCK_CNT consecutive good headers are seen,
//            then forwards payloads and drops lock when ERR_CNT bad headers
//            land inside one WIN-block window.
// Ports    : clk, rst_n (async, active low), enable
//            blk_in[WIDTH-1:0], blk_valid      - word from deserializer
//            slip                              - one-cycle bit-slip request
//            blk_out[WIDTH-3:0], blk_type,
//            blk_err, blk_out_valid            - forwarded block (registered)
//            locked, lock_lost                 - lock status / loss pulse
//            slip_count[7:0]                   - saturating slip counter
// Revision : 1.0 - initial release
// ============================================================================
module block_align_ctrl #(
  parameter int WIDTH    = 130,
  parameter int LOCK_CNT = 8,
  parameter int WIN      = 64,
  parameter int ERR_CNT  = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] blk_in,
  input  logic             blk_valid,
  output logic             slip,
  output logic [WIDTH-3:0] blk_out,
  output logic             blk_type,
  output logic             blk_err,
  output logic             blk_out_valid,
  output logic             locked,
  output logic             lock_lost,
  output logic [7:0]       slip_count
);

  localparam int WW = $clog2(WIN + 1);
  localparam logic [7:0]    LOCK_V = 8'(LOCK_CNT);
  localparam logic [WW-1:0] WIN_V  = WW'(WIN);
  localparam logic [WW-1:0] ERR_V  = WW'(ERR_CNT);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_HUNT   = 3'd1,
    S_SKIP   = 3'd2,
    S_VERIFY = 3'd3,
    S_LOCKED = 3'd4
  } state_t;

  state_t            state_q, state_d;
  logic [7:0]        good_cnt_q, good_cnt_d;
  logic [WW-1:0]     win_cnt_q, win_cnt_d;
  logic [WW-1:0]     err_cnt_q, err_cnt_d;
  logic              slip_q, slip_d;
  logic [WIDTH-3:0]  blk_out_q, blk_out_d;
  logic              blk_type_q, blk_type_d;
  logic              blk_err_q, blk_err_d;
  logic              blk_out_valid_q, blk_out_valid_d;
  logic              locked_q, locked_d;
  logic              lock_lost_q, lock_lost_d;
  logic [7:0]        slip_count_q, slip_count_d;

  logic [1:0]        hdr;
  logic              good;
  logic [7:0]        good_next;
  logic [WW-1:0]     win_next;
  logic [WW-1:0]     err_next;

  assign hdr       = blk_in[WIDTH-1 -: 2];
  assign good      = (hdr == 2'b01) || (hdr == 2'b10);
  // good_cnt is held at zero in HUNT, so HUNT and VERIFY share this increment.
  assign good_next = good_cnt_q + 8'd1;
  assign win_next  = win_cnt_q + WW'(1);
  assign err_next  = err_cnt_q + (good ? WW'(0) : WW'(1));

  always_comb begin
    state_d         = state_q;
    good_cnt_d      = good_cnt_q;
    win_cnt_d       = win_cnt_q;
    err_cnt_d       = err_cnt_q;
    slip_d          = 1'b0;
    blk_out_d       = blk_out_q;
    blk_type_d      = blk_type_q;
    blk_err_d       = blk_err_q;
    blk_out_valid_d = 1'b0;
    lock_lost_d     = 1'b0;

    if (!enable) begin
      state_d    = S_IDLE;
      good_cnt_d = '0;
      win_cnt_d  = '0;
      err_cnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE: state_d = S_HUNT;

        S_HUNT, S_VERIFY: begin
          if (blk_valid) begin
            if (good) begin
              if (good_next == LOCK_V) begin
                state_d    = S_LOCKED;
                good_cnt_d = '0;
                win_cnt_d  = '0;
                err_cnt_d  = '0;
              end else begin
                state_d    = S_VERIFY;
                good_cnt_d = good_next;
              end
            end else begin
              state_d    = S_SKIP;
              slip_d     = 1'b1;
              good_cnt_d = '0;
            end
          end
        end

        // The word after a slip straddles the old and new boundary: drop it.
        S_SKIP: if (blk_valid) state_d = S_HUNT;

        S_LOCKED: begin
          if (blk_valid) begin
            blk_out_d       = blk_in[WIDTH-3:0];
            blk_type_d      = (hdr == 2'b01);
            blk_err_d       = !good;
            blk_out_valid_d = 1'b1;
            // Loss-of-lock check wins over the end-of-window clear.
            if (!good && (err_next == ERR_V)) begin
              state_d     = S_HUNT;
              lock_lost_d = 1'b1;
              win_cnt_d   = '0;
              err_cnt_d   = '0;
            end else if (win_next == WIN_V) begin
              win_cnt_d = '0;
              err_cnt_d = '0;
            end else begin
              win_cnt_d = win_next;
              err_cnt_d = err_next;
            end
          end
        end

        default: state_d = S_IDLE;
      endcase
    end

    locked_d     = (state_d == S_LOCKED);
    slip_count_d = (slip_d && (slip_count_q != 8'hFF)) ? slip_count_q + 8'd1
                                                         : slip_count_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      good_cnt_q      <= '0;
      win_cnt_q       <= '0;
      err_cnt_q       <= '0;
      slip_q          <= 1'b0;
      blk_out_q       <= '0;
      blk_type_q      <= 1'b0;
      blk_err_q       <= 1'b0;
      blk_out_valid_q <= 1'b0;
      locked_q        <= 1'b0;
      lock_lost_q     <= 1'b0;
      slip_count_q    <= '0;
    end else begin
      state_q         <= state_d;
      good_cnt_q      <= good_cnt_d;
      win_cnt_q       <= win_cnt_d;
      err_cnt_q       <= err_cnt_d;
      slip_q          <= slip_d;
      blk_out_q       <= blk_out_d;
      blk_type_q      <= blk_type_d;
      blk_err_q       <= blk_err_d;
      blk_out_valid_q <= blk_out_valid_d;
      locked_q        <= locked_d;
      lock_lost_q     <= lock_lost_d;
      slip_count_q    <= slip_count_d;
    end
  end

  assign slip          = slip_q;
  assign blk_out       = blk_out_q;
  assign blk_type      = blk_type_q;
  assign blk_err       = blk_err_q;
  assign blk_out_valid = blk_out_valid_q;
  assign locked        = locked_q;
  assign lock_lost     = lock_lost_q;
  assign slip_count    = slip_count_q;

endmodule
`default_nettype wire

// File: tb/tb_block_align_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_block_align_ctrl
// Purpose  : Directed self-checking bench for block_align_ctrl
//            (WIDTH=130, LOCK_CNT=8, WIN=64, ERR_CNT=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_block_align_ctrl;

  logic         clk;
  logic         rst_n;
  logic         enable;
  logic [129:0] blk_in;
  logic         blk_valid;
  logic         slip;
  logic [127:0] blk_out;
  logic         blk_type;
  logic         blk_err;
  logic         blk_out_valid;
  logic         locked;
  logic         lock_lost;
  logic [7:0]   slip_count;

  int checks   = 0;
  int failures = 0;

  localparam logic [127:0] PL_A5 = {16{8'hA5}};
  localparam logic [127:0] PL_3C = {16{8'h3C}};

  block_align_ctrl #(
    .WIDTH(130), .LOCK_CNT(8), .WIN(64), .ERR_CNT(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .blk_in(blk_in), .blk_valid(blk_valid),
    .slip(slip), .blk_out(blk_out), .blk_type(blk_type), .blk_err(blk_err),
    .blk_out_valid(blk_out_valid), .locked(locked), .lock_lost(lock_lost),
    .slip_count(slip_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; presents one word for one clock and returns at
  // the next falling edge, when the registered response is visible.
  task automatic send(input logic [1:0] hdr, input logic [127:0] pl);
    blk_in    = {hdr, pl};
    blk_valid = 1'b1;
    @(negedge clk);
    blk_valid = 1'b0;
  endtask

  task automatic send_good(input int n);
    for (int i = 0; i < n; i++) send(2'b10, 128'(i));
  endtask

  int errs;
  int lost;
  int held;

  initial begin
    rst_n     = 1'b0;
    enable    = 1'b0;
    blk_in    = '0;
    blk_valid = 1'b0;
    repeat (2) @(negedge clk);

    // ---------------- reset state
    check("rst_slip", slip, 0);
    check("rst_valid", blk_out_valid, 0);
    check("rst_locked", locked, 0);
    check("rst_lost", lock_lost, 0);
    check("rst_slipcnt", slip_count, 0);
    check("rst_blkout", blk_out, 0);
    check("rst_type", blk_type, 0);
    check("rst_err", blk_err, 0);

    rst_n  = 1'b1;
    enable = 1'b1;
    @(negedge clk);                       // IDLE -> HUNT

    // ---------------- aligned stream
    send_good(7);
    check("align_pre_lock", locked, 0);
    send(2'b10, 128'h7);
    check("align_locked", locked, 1);
    check("align_lockblk_not_fwd", blk_out_valid, 0);
    send(2'b01, PL_A5);                   // window block 1
    check("fwd_valid", blk_out_valid, 1);
    check("fwd_type", blk_type, 1);
    check("fwd_data", blk_out, PL_A5);
    check("fwd_err", blk_err, 0);
    @(negedge clk);
    check("fwd_pulse_end", blk_out_valid, 0);
    check("fwd_data_hold", blk_out, PL_A5);

    // ---------------- loss of lock: bad headers on blocks 10,20,30,40
    for (int b = 10; b <= 40; b++) begin
      if (b % 10 == 0) begin
        send(2'b11, PL_3C);
        check("lol_blk_err", blk_err, 1);
        check("lol_no_slip", slip, 0);
        if (b < 40) check("lol_still_locked", locked, 1);
      end else begin
        send(2'b10, PL_3C);
      end
    end
    check("lol_pulse", lock_lost, 1);
    check("lol_locked", locked, 0);
    @(negedge clk);
    check("lol_pulse_end", lock_lost, 0);

    // relock from HUNT
    send_good(8);
    check("relock", locked, 1);

    // ---------------- 3 bad per window over 3 windows: lock held
    errs = 0; lost = 0; held = 1;
    for (int w = 0; w < 3; w++) begin
      for (int p = 1; p <= 64; p++) begin
        send((p >= 5 && p <= 7) ? 2'b00 : 2'b01, 128'(p));
        if (blk_out_valid && blk_err) errs++;
        if (lock_lost) lost++;
        if (!locked) held = 0;
      end
    end
    check("win3_errs", 128'(errs), 128'd9);
    check("win3_no_lost", 128'(lost), 128'd0);
    check("win3_held", 128'(held), 128'd1);

    // ---------------- boundary: 4th bad on block 64 of a window
    for (int p = 1; p <= 63; p++)
      send((p % 10 == 0 && p <= 30) ? 2'b11 : 2'b10, 128'(p));
    check("bnd_pre_locked", locked, 1);
    send(2'b00, 128'd64);
    check("bnd_lost", lock_lost, 1);
    check("bnd_locked", locked, 0);
    check("bnd_no_slip", slip, 0);

    // ---------------- misaligned start (state HUNT)
    send(2'b11, 128'd1);
    check("mis_slip1", slip, 1);
    send(2'b11, 128'd2);                  // skipped
    check("mis_skip_noslip", slip, 0);
    send(2'b11, 128'd3);
    check("mis_slip2", slip, 1);
    check("mis_slipcnt", slip_count, 2);
    check("mis_locked", locked, 0);

    // ---------------- VERIFY break
    send(2'b10, 128'd0);                  // skipped word
    send_good(5);
    send(2'b00, 128'd0);
    check("vb_slip", slip, 1);
    check("vb_slipcnt", slip_count, 3);
    send(2'b10, 128'd0);                  // skipped word
    send_good(7);
    check("vb_not_yet", locked, 0);
    send(2'b10, 128'd0);
    check("vb_locked", locked, 1);

    // ---------------- enable drop while LOCKED
    enable = 1'b0;
    send(2'b11, 128'd0);
    check("en_locked", locked, 0);
    check("en_no_lost", lock_lost, 0);
    check("en_no_slip", slip, 0);
    check("en_no_fwd", blk_out_valid, 0);
    enable = 1'b1;
    @(negedge clk);                       // IDLE -> HUNT

    // ---------------- reset mid-VERIFY
    send_good(3);
    rst_n = 1'b0;
    #1;
    check("rstm_slipcnt", slip_count, 0);
    check("rstm_locked", locked, 0);
    check("rstm_blkout", blk_out, 0);
    check("rstm_valid", blk_out_valid, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);                       // IDLE -> HUNT
    send_good(7);
    check("rstm_cnt_cleared", locked, 0);
    send(2'b10, 128'd0);
    check("rstm_relock", locked, 1);

    // ---------------- slip_count saturation (300 slip pulses)
    enable = 1'b0;
    @(negedge clk);
    enable = 1'b1;
    @(negedge clk);                       // HUNT
    for (int i = 0; i < 508; i++) send(2'b11, 128'(i));
    check("sat_254", slip_count, 254);
    for (int i = 0; i < 92; i++) send(2'b00, 128'(i));
    check("sat_255", slip_count, 255);
    check("sat_locked", locked, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
